rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux_if.sv | 18 +
 rtl/rr_arb_mux.sv | 52 +++++
 tb/tb_rr_arb_mux.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: channel-side and output-side handshake bundle for rr_arb_mux.
interface rr_arb_mux_if #(parameter int N = 8, parameter int CH = 4);
   localparam int SW = $clog2(CH);
   logic          enable;
   logic          mode;
   logic [SW-1:0] select;
   logic [CH-1:0] in_valid;
   logic [CH*N-1:0] in_data;
   logic [CH-1:0] in_ready;
   logic          out_valid;
   logic [N-1:0]  out_data;
   logic [SW-1:0] out_ch;
   logic          out_ready;
   modport slave (input enable, mode, select, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_ch);
   modport master (output enable, mode, select, in_valid, in_data, out_ready,
                   input in_ready, out_valid, out_data, out_ch);
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CH-to-1 mux with fixed-select or round-robin grant into one registered output entry.
module rr_arb_mux #(parameter int N = 8, parameter int CH = 4) (
   input logic clk,
   input logic rst_n,
   rr_arb_mux_if.slave bus
);
   localparam int SW = $clog2(CH);
   localparam logic [SW:0] CHW = (SW+1)'(CH);
   logic [SW-1:0] ptr, rr_g, g, ptr_nxt;
   logic [SW:0] idx, g_inc;
   logic found, g_ok, can_accept, xfer;
   logic [N-1:0] g_data;
   always_comb begin
      found = 1'b0;
      rr_g = '0;
      idx = '0;
      g_data = '0;
      for (int i = 0; i < CH; i++) begin
         idx = {1'b0, ptr} + (SW+1)'(i);
         idx = idx >= CHW ? idx - CHW : idx;
         if (!found && bus.in_valid[idx[SW-1:0]]) begin
            found = 1'b1;
            rr_g = idx[SW-1:0];
         end
      end
      g = bus.mode ? rr_g : bus.select;
      g_ok = bus.mode ? found : ({1'b0, bus.select} < CHW);
      can_accept = rst_n & bus.enable & (~bus.out_valid | bus.out_ready);
      bus.in_ready = (g_ok & can_accept) ? CH'(1) << g : '0;
      xfer = |(bus.in_ready & bus.in_valid);
      for (int k = 0; k < CH; k++)
         if (g == SW'(k)) g_data = bus.in_data[k*N +: N];
      g_inc = {1'b0, g} + 1'b1;
      ptr_nxt = g_inc == CHW ? '0 : g_inc[SW-1:0];
   end
   // a refill takes priority over a drain so the output never bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_ch <= '0;
         ptr <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data <= g_data;
         bus.out_ch <= g;
         if (bus.mode) ptr <= ptr_nxt;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of rr_arb_mux with CH=4 and CH=3 instances.
module tb_rr_arb_mux;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [1:0] exp_ch4 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0] exp_ch3 [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
   logic [7:0] exp_d;
   always #5 clk = ~clk;
   rr_arb_mux_if #(.N(8), .CH(4)) b4();
   rr_arb_mux_if #(.N(8), .CH(3)) b3();
   rr_arb_mux #(.N(8), .CH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   rr_arb_mux #(.N(8), .CH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   task automatic drv4(input logic en, input logic md, input logic [1:0] sel, input logic [3:0] v, input logic rdy);
      b4.enable = en; b4.mode = md; b4.select = sel; b4.in_valid = v; b4.out_ready = rdy;
   endtask

   task automatic drv3(input logic en, input logic md, input logic [1:0] sel, input logic [2:0] v, input logic rdy);
      b3.enable = en; b3.mode = md; b3.select = sel; b3.in_valid = v; b3.out_ready = rdy;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drv4(1, 0, 0, 4'hf, 1); b4.in_data = 32'h44A52211;
      drv3(0, 0, 0, 3'b000, 1); b3.in_data = 24'h332211;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", b4.out_valid); end
      checks++; if (b4.out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", b4.out_data); end
      checks++; if (b4.out_ch !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d want 0", b4.out_ch); end
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", b4.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      drv4(1, 0, 1, 4'b0010, 0); b4.in_data = 32'h44A57711;
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h77) begin errors++; $display("FAIL first_xfer: got v=%b d=%h want v=1 d=77", b4.out_valid, b4.out_data); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", b4.out_valid); end
      checks++; if (b4.out_data !== 8'h00) begin errors++; $display("FAIL async_data: got %h want 00", b4.out_data); end
      checks++; if (b4.out_ch !== 2'd0) begin errors++; $display("FAIL async_ch: got %0d want 0", b4.out_ch); end
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL async_ready: got %b want 0000", b4.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (b4.in_ready !== 4'b0010) begin errors++; $display("FAIL post_rst_ready: got %b want 0010", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h77 || b4.out_ch !== 2'd1) begin errors++; $display("FAIL post_rst_xfer: got v=%b d=%h ch=%0d want v=1 d=77 ch=1", b4.out_valid, b4.out_data, b4.out_ch); end
      drv4(1, 0, 0, 4'b0000, 1);
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain: got %b want 0", b4.out_valid); end
   endtask

   task automatic test_mode0;
      drv4(1, 0, 2, 4'hf, 1); b4.in_data = 32'h44A52211;
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL m0_ready: got %b want 0100", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'hA5 || b4.out_ch !== 2'd2) begin errors++; $display("FAIL m0_out: got v=%b d=%h ch=%0d want v=1 d=a5 ch=2", b4.out_valid, b4.out_data, b4.out_ch); end
      drv4(1, 0, 2, 4'b0000, 1);
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL m0_ready_novalid: got %b want 0100", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 8'hA5 || b4.out_ch !== 2'd2) begin errors++; $display("FAIL m0_drain_hold: got v=%b d=%h ch=%0d want v=0 d=a5 ch=2", b4.out_valid, b4.out_data, b4.out_ch); end
   endtask

   task automatic test_fairness;
      drv4(1, 1, 0, 4'hf, 1); b4.in_data = 32'hD3C2B1A0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         exp_d = 8'hA0 + 8'h11 * exp_ch4[i];
         checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== exp_ch4[i] || b4.out_data !== exp_d) begin errors++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, b4.out_valid, b4.out_ch, b4.out_data, exp_ch4[i], exp_d); end
      end
      drv4(1, 1, 0, 4'b0000, 1);
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", b4.out_valid); end
   endtask

   task automatic test_skip_wrap;
      drv4(1, 1, 0, 4'b0100, 1); b4.in_data = 32'h44332211;
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL skip_setup: got %b want 0100", b4.in_ready); end
      @(negedge clk);
      drv4(1, 1, 0, 4'b0101, 1);
      #1;
      checks++; if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b want 0001", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_ch !== 2'd0 || b4.out_data !== 8'h11) begin errors++; $display("FAIL wrap_out0: got ch=%0d d=%h want ch=0 d=11", b4.out_ch, b4.out_data); end
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL skip_grant2: got %b want 0100", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_ch !== 2'd2 || b4.out_data !== 8'h33) begin errors++; $display("FAIL skip_out2: got ch=%0d d=%h want ch=2 d=33", b4.out_ch, b4.out_data); end
      drv4(1, 1, 0, 4'b0000, 1);
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      drv4(1, 0, 0, 4'b0001, 0); b4.in_data = 32'h44335A3C;
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h3C) begin errors++; $display("FAIL bp_load: got v=%b d=%h want v=1 d=3c", b4.out_valid, b4.out_data); end
      drv4(1, 1, 0, 4'b0010, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (b4.in_ready !== 4'b0000 || b4.out_data !== 8'h3C || b4.out_valid !== 1'b1 || b4.out_ch !== 2'd0) begin errors++; $display("FAIL bp_hold[%0d]: got r=%b v=%b d=%h ch=%0d want r=0000 v=1 d=3c ch=0", i, b4.in_ready, b4.out_valid, b4.out_data, b4.out_ch); end
         @(negedge clk);
      end
      b4.out_ready = 1'b1;
      #1;
      checks++; if (b4.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_refill_ready: got %b want 0010", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h5A || b4.out_ch !== 2'd1) begin errors++; $display("FAIL bp_refill: got v=%b d=%h ch=%0d want v=1 d=5a ch=1", b4.out_valid, b4.out_data, b4.out_ch); end
      drv4(1, 1, 0, 4'b0000, 1);
      @(negedge clk);
   endtask

   task automatic test_enable;
      drv4(1, 1, 0, 4'hf, 0); b4.in_data = 32'hD3C2B1A0;
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL en_pre_ready: got %b want 0100", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'd2 || b4.out_data !== 8'hC2) begin errors++; $display("FAIL en_load: got v=%b ch=%0d d=%h want v=1 ch=2 d=c2", b4.out_valid, b4.out_ch, b4.out_data); end
      drv4(0, 1, 0, 4'hf, 1);
      #1;
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready: got %b want 0000", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 8'hC2 || b4.in_ready !== 4'b0000) begin errors++; $display("FAIL en_off_drain: got v=%b d=%h r=%b want v=0 d=c2 r=0000", b4.out_valid, b4.out_data, b4.in_ready); end
      drv4(1, 1, 0, 4'hf, 1);
      #1;
      checks++; if (b4.in_ready !== 4'b1000) begin errors++; $display("FAIL en_ptr_held: got %b want 1000", b4.in_ready); end
      @(negedge clk);
      checks++; if (b4.out_ch !== 2'd3 || b4.out_data !== 8'hD3) begin errors++; $display("FAIL en_resume: got ch=%0d d=%h want ch=3 d=d3", b4.out_ch, b4.out_data); end
      drv4(0, 0, 0, 4'b0000, 1);
   endtask

   task automatic test_ch3;
      drv3(1, 1, 0, 3'b100, 1); b3.in_data = 24'h332211;
      #1;
      checks++; if (b3.in_ready !== 3'b100) begin errors++; $display("FAIL c3_grant2: got %b want 100", b3.in_ready); end
      @(negedge clk);
      checks++; if (b3.out_ch !== 2'd2 || b3.out_data !== 8'h33) begin errors++; $display("FAIL c3_out2: got ch=%0d d=%h want ch=2 d=33", b3.out_ch, b3.out_data); end
      drv3(1, 1, 0, 3'b111, 1);
      #1;
      checks++; if (b3.in_ready !== 3'b001) begin errors++; $display("FAIL c3_wrap: got %b want 001", b3.in_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_d = 8'h11 + 8'h11 * exp_ch3[i];
         checks++; if (b3.out_valid !== 1'b1 || b3.out_ch !== exp_ch3[i] || b3.out_data !== exp_d) begin errors++; $display("FAIL c3_seq[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, b3.out_valid, b3.out_ch, b3.out_data, exp_ch3[i], exp_d); end
      end
      drv3(1, 0, 3, 3'b111, 1);
      #1;
      checks++; if (b3.in_ready !== 3'b000) begin errors++; $display("FAIL c3_sel_oob: got %b want 000", b3.in_ready); end
      @(negedge clk);
      checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL c3_oob_noxfer: got %b want 0", b3.out_valid); end
      drv3(1, 0, 2, 3'b111, 1);
      #1;
      checks++; if (b3.in_ready !== 3'b100) begin errors++; $display("FAIL c3_sel2: got %b want 100", b3.in_ready); end
      @(negedge clk);
      checks++; if (b3.out_valid !== 1'b1 || b3.out_ch !== 2'd2 || b3.out_data !== 8'h33) begin errors++; $display("FAIL c3_sel2_out: got v=%b ch=%0d d=%h want v=1 ch=2 d=33", b3.out_valid, b3.out_ch, b3.out_data); end
      drv3(0, 0, 0, 3'b000, 1);
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_fairness();
      test_skip_wrap();
      test_backpressure();
      test_enable();
      test_ch3();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
